// File: rtl/sdm_int_sched.sv
// Round-robin integrate-and-dump scheduler sharing one integrator between NCH channels.
// Each conversion clears the integrator, enables it for N clocks, then captures a channel-tagged result.
module sdm_int_sched #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned D_WIDTH = 9,
   parameter int unsigned OSR_W   = 8
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_run,
   input  logic [NCH-1:0]                       i_ch_mask,
   input  logic [OSR_W-1:0]                     i_osr,
   output logic                                 o_int_rst,
   output logic                                 o_int_en,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] o_ch_sel,
   input  logic [D_WIDTH-1:0]                   i_int_y,
   output logic [D_WIDTH-1:0]                   o_data,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] o_ch,
   output logic                                 o_valid,
   input  logic                                 i_ready,
   output logic                                 o_busy
);

   localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_INTEG   = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [OSR_W-1:0]   cnt_q, cnt_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [CH_W-1:0]    last_q, last_d;
   logic [D_WIDTH-1:0] data_q, data_d;
   logic [CH_W-1:0]    och_q, och_d;
   logic               valid_q, valid_d;
   logic               int_rst_q, int_en_q, busy_q;

   logic [CH_W-1:0]    base_c, hi_pick_c, lo_pick_c, next_ch_c;
   logic               hi_found_c, any_ch_c;

   // Round-robin pick: lowest enabled index above the last served channel, else lowest enabled.
   always_comb begin
      base_c     = (state_q == S_CAPTURE) ? ch_q : last_q;
      hi_pick_c  = '0;
      lo_pick_c  = '0;
      hi_found_c = 1'b0;
      any_ch_c   = |i_ch_mask;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         if (i_ch_mask[i]) begin
            lo_pick_c = CH_W'(i);
            if (CH_W'(i) > base_c) begin
               hi_pick_c  = CH_W'(i);
               hi_found_c = 1'b1;
            end
         end
      end
      next_ch_c = hi_found_c ? hi_pick_c : lo_pick_c;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      last_d  = last_q;
      data_d  = data_q;
      och_d   = och_q;
      valid_d = valid_q;

      if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (i_run && any_ch_c) begin
               state_d = S_CLEAR;
               ch_d    = next_ch_c;
            end
         end
         S_CLEAR: begin
            cnt_d   = (i_osr == '0) ? OSR_W'(1) : i_osr;
            state_d = S_INTEG;
         end
         S_INTEG: begin
            if (cnt_q == OSR_W'(1)) begin
               state_d = (valid_q && !i_ready) ? S_WAIT : S_CAPTURE;
            end else begin
               cnt_d = cnt_q - OSR_W'(1);
            end
         end
         S_WAIT: begin
            if (!valid_q || i_ready) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            // A new load overrides any handshake clear at the same edge.
            data_d  = i_int_y;
            och_d   = ch_q;
            valid_d = 1'b1;
            last_d  = ch_q;
            if (i_run && any_ch_c) begin
               state_d = S_CLEAR;
               ch_d    = next_ch_c;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Integrator controls and busy are registered from the next state so they align with it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ch_q      <= '0;
         last_q    <= CH_W'(NCH - 1);
         data_q    <= '0;
         och_q     <= '0;
         valid_q   <= 1'b0;
         int_rst_q <= 1'b0;
         int_en_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ch_q      <= ch_d;
         last_q    <= last_d;
         data_q    <= data_d;
         och_q     <= och_d;
         valid_q   <= valid_d;
         int_rst_q <= (state_d == S_CLEAR);
         int_en_q  <= (state_d == S_INTEG);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   assign o_int_rst = int_rst_q;
   assign o_int_en  = int_en_q;
   assign o_ch_sel  = ch_q;
   assign o_data    = data_q;
   assign o_ch      = och_q;
   assign o_valid   = valid_q;
   assign o_busy    = busy_q;

endmodule

// File: tb/tb_sdm_int_sched.sv
// Bench for sdm_int_sched: behavioural integrator, round-robin result model and directed/random steps.
module tb_sdm_int_sched;

   localparam int NCH = 4;
   localparam int DW  = 9;
   localparam int OW  = 8;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_run;
   logic [NCH-1:0] i_ch_mask;
   logic [OW-1:0] i_osr;
   logic          o_int_rst, o_int_en;
   logic [CW-1:0] o_ch_sel, o_ch;
   logic [DW-1:0] i_int_y, o_data;
   logic          o_valid, i_ready, o_busy;

   sdm_int_sched #(.NCH(NCH), .D_WIDTH(DW), .OSR_W(OW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(i_run), .i_ch_mask(i_ch_mask), .i_osr(i_osr),
      .o_int_rst(o_int_rst), .o_int_en(o_int_en), .o_ch_sel(o_ch_sel), .i_int_y(i_int_y),
      .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   // Integrator with sync clear and enable, fed by the channel mux.
   logic [7:0] x_ch [NCH];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         i_int_y <= '0;
      else if (o_int_rst) i_int_y <= '0;
      else if (o_int_en)  i_int_y <= i_int_y + DW'(x_ch[o_ch_sel]);
   end

   typedef struct {int ch; int data;} exp_t;
   exp_t exp_q[$];
   exp_t e;
   int   got_ch[$];
   int   vectors = 0, miscompares = 0;
   int   model_last = NCH - 1;
   int   cur_ch = -1;
   int   cyc = 0, rst_cnt = 0, en_cnt = 0, load_cnt = 0;
   logic pv, r_edge;
   logic [DW-1:0] pdata;
   logic [CW-1:0] pch;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int pick_ch(input int last, input logic [NCH-1:0] m);
      for (int i = 1; i <= NCH; i++) begin
         int c;
         c = (last + i) % NCH;
         if (((m >> c) & 1) != 0) return c;
      end
      return -1;
   endfunction

   function automatic int nval(input logic [OW-1:0] o);
      return (o == 0) ? 1 : int'(o);
   endfunction

   // One clock: advance, then model conversions and check every result load / hold.
   task step();
      r_edge = i_ready; pv = o_valid; pdata = o_data; pch = o_ch;
      @(posedge clk); #1; cyc++;
      if (o_int_rst) begin
         cur_ch = pick_ch(model_last, i_ch_mask);
         model_last = cur_ch;
         exp_q.push_back('{cur_ch, (nval(i_osr) * int'(x_ch[cur_ch & 3])) % 512});
         rst_cnt++;
         chk("ch_sel_clear", 32'(o_ch_sel), cur_ch);
      end
      if (o_int_en) begin
         en_cnt++;
         chk("ch_sel_integ", 32'(o_ch_sel), cur_ch);
      end
      if (o_valid && (!pv || r_edge)) begin
         load_cnt++;
         got_ch.push_back(int'(o_ch));
         if (exp_q.size() == 0) chk("sb_unexpected", 32'(o_valid), 0);
         else begin
            e = exp_q.pop_front();
            chk("sb_ch", 32'(o_ch), e.ch);
            chk("sb_data", 32'(o_data), e.data);
         end
      end else if (pv && !r_edge) begin
         chk("hold_valid", 32'(o_valid), 1);
         chk("hold_data", 32'(o_data), 32'(pdata));
         chk("hold_ch", 32'(o_ch), 32'(pch));
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      i_ready = 1'b1;
      i_run   = 1'b0;
      while ((o_busy || o_valid) && n < 300) begin step(); n++; end
      chk("idle_timeout", 32'(n < 300), 1);
   endtask

   task automatic wait_start();
      int n = 0;
      do begin step(); n++; end while (!o_int_rst && n < 10);
      chk("start_timeout", 32'(o_int_rst), 1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rst"}, 32'(o_int_rst), 0);
      chk({tag, "_en"}, 32'(o_int_en), 0);
      chk({tag, "_sel"}, 32'(o_ch_sel), 0);
      chk({tag, "_data"}, 32'(o_data), 0);
      chk({tag, "_ch"}, 32'(o_ch), 0);
      chk({tag, "_valid"}, 32'(o_valid), 0);
      chk({tag, "_busy"}, 32'(o_busy), 0);
   endtask

   initial begin
      int n;
      logic changed;
      rst_n = 1'b0; i_run = 1'b0; i_ch_mask = '0; i_osr = '0; i_ready = 1'b0;
      for (int i = 0; i < NCH; i++) x_ch[i] = '0;
      #12;
      check_all_zero("reset");
      #10 rst_n = 1'b1;

      // Latency and back-to-back cadence, N=4, x=1 on ch0.
      i_ch_mask = 4'b0001; i_osr = 8'd4; x_ch[0] = 8'd1; i_ready = 1'b1; i_run = 1'b1;
      wait_start();
      chk("lat_c0_en", 32'(o_int_en), 0);
      chk("lat_c0_busy", 32'(o_busy), 1);
      for (int c = 1; c <= 18; c++) begin
         step();
         chk("lat_rst", 32'(o_int_rst), 32'(c % 6 == 0));
         chk("lat_en", 32'(o_int_en), 32'((c % 6 >= 1) && (c % 6 <= 4)));
         chk("lat_valid", 32'(o_valid), 32'(c % 6 == 0));
         if (c == 6) begin
            chk("lat_data", 32'(o_data), 4);
            chk("lat_ch", 32'(o_ch), 0);
         end
      end
      wait_idle();

      // Round robin over mask 1010.
      i_ch_mask = 4'b1010; i_osr = 8'd2; x_ch[1] = 8'd5; x_ch[3] = 8'd7;
      got_ch.delete(); i_run = 1'b1; n = 0;
      while (got_ch.size() < 4 && n < 100) begin step(); n++; end
      i_run = 1'b0;
      chk("rr_count", 32'(got_ch.size() >= 4), 1);
      chk("rr_0", got_ch[0], 1);
      chk("rr_1", got_ch[1], 3);
      chk("rr_2", got_ch[2], 1);
      chk("rr_3", got_ch[3], 3);
      wait_idle();

      // Backpressure: second conversion parks in WAIT without extra accumulation.
      i_ch_mask = 4'b0001; i_osr = 8'd3; x_ch[0] = 8'd9; i_ready = 1'b0; i_run = 1'b1;
      for (int c = 0; c < 20; c++) step();
      chk("bp_valid", 32'(o_valid), 1);
      chk("bp_data", 32'(o_data), 27);
      chk("bp_en", 32'(o_int_en), 0);
      chk("bp_busy", 32'(o_busy), 1);
      chk("bp_y", 32'(i_int_y), 27);
      i_run = 1'b0; i_ready = 1'b1;
      step();
      chk("bp_gap", 32'(o_valid), 0);
      step();
      chk("bp_second_valid", 32'(o_valid), 1);
      chk("bp_second_data", 32'(o_data), 27);
      chk("bp_idle_busy", 32'(o_busy), 0);
      wait_idle();

      // Empty mask never starts; osr=0 integrates exactly once.
      i_ch_mask = '0; i_run = 1'b1; rst_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("mask0_busy", 32'(o_busy), 0);
      end
      chk("mask0_rst", rst_cnt, 0);
      i_ch_mask = 4'b0100; i_osr = 8'd0; x_ch[2] = 8'd13; en_cnt = 0; load_cnt = 0;
      wait_start();
      i_run = 1'b0; n = 0;
      while (load_cnt == 0 && n < 20) begin step(); n++; end
      chk("osr0_en", en_cnt, 1);
      chk("osr0_data", 32'(o_data), 13);
      chk("osr0_ch", 32'(o_ch), 2);
      wait_idle();

      // Run drops in the 3rd INTEG cycle of N=8: result still delivered, then idle.
      i_ch_mask = 4'b0001; i_osr = 8'd8; x_ch[0] = 8'd3; i_run = 1'b1; en_cnt = 0; n = 0;
      while (en_cnt < 3 && n < 20) begin step(); n++; end
      i_run = 1'b0; rst_cnt = 0; load_cnt = 0;
      wait_idle();
      for (int c = 0; c < 5; c++) step();
      chk("stop_loads", load_cnt, 1);
      chk("stop_rst", rst_cnt, 0);
      chk("stop_data", 32'(o_data), 24);
      chk("stop_busy", 32'(o_busy), 0);

      // Async reset mid-INTEG on ch2; restart must pick ch1 again.
      i_ch_mask = 4'b0110; i_osr = 8'd5; x_ch[1] = 8'd2; x_ch[2] = 8'd4; i_run = 1'b1;
      load_cnt = 0; n = 0;
      while (load_cnt < 1 && n < 50) begin step(); n++; end
      en_cnt = 0; n = 0;
      while (en_cnt < 2 && n < 20) begin step(); n++; end
      chk("rst_pre_sel", 32'(o_ch_sel), 2);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      @(posedge clk); #4;
      rst_n = 1'b1;
      exp_q.delete(); got_ch.delete(); model_last = NCH - 1; load_cnt = 0; n = 0;
      while (load_cnt < 1 && n < 50) begin step(); n++; end
      i_run = 1'b0;
      chk("rst_first_ch", got_ch[0], 1);
      wait_idle();

      // Random rounds: random config, ready, and a mid-run mask/osr change.
      for (int r = 0; r < 6; r++) begin
         i_ch_mask = NCH'($urandom_range(1, 15));
         i_osr = OW'($urandom_range(0, 12));
         for (int i = 0; i < NCH; i++) x_ch[i] = 8'($urandom);
         i_run = 1'b1; changed = 1'b0;
         for (int k = 0; k < 120; k++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if (k >= 60 && !changed && o_int_en) begin
               i_ch_mask = NCH'($urandom_range(1, 15));
               i_osr = OW'($urandom_range(0, 12));
               changed = 1'b1;
            end
            step();
         end
         wait_idle();
         chk("sb_drain", exp_q.size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sdm_int_sched.md
Name: sdm_int_sched

Overview:
- Time-shares one integrator datapath (i_x → o_y accumulator with enable and synchronous reset) between NCH sensor channels in the iCESDM readout.
- Each conversion is integrate-and-dump: clear the integrator, enable it for a programmable number of clocks, capture the result, then move to the next enabled channel in round-robin order.
- Results go downstream over a valid/ready handshake tagged with the channel index.

Parameters:
- NCH, 4, number of time-shared channels (2..16).
- D_WIDTH, 9, integrator output width; equals the integrator's I_WIDTH+1.
- OSR_W, 8, width of the integration-length field.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_run  in  1  level; high = keep converting, low = finish the current conversion, then idle.
- i_ch_mask  in  NCH  per-channel enable; sampled in CLEAR.
- i_osr  in  OSR_W  integration length N in clocks; 0 is treated as 1; sampled in CLEAR.
- o_int_rst  out  1  synchronous clear to the integrator.
- o_int_en  out  1  integrator enable.
- o_ch_sel  out  clog2(NCH)  selects the input mux in front of the integrator.
- i_int_y  in  D_WIDTH  integrator output (registered).
- o_data  out  D_WIDTH  captured result.
- o_ch  out  clog2(NCH)  channel tag of o_data.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - State = IDLE; all outputs 0; internal last-channel pointer = NCH-1, so the first pick is the lowest enabled channel.
  - Reset asserted mid-conversion aborts it. No o_valid is produced, and a pending o_valid is dropped.
- IDLE:
  - o_int_en=0, o_int_rst=0.
  - If i_run=1 and i_ch_mask != 0 → CLEAR next cycle.
  - If i_ch_mask == 0, stay in IDLE.
- CLEAR (1 cycle):
  - o_int_rst=1, o_int_en=0.
  - Latch N = (i_osr==0 ? 1 : i_osr).
  - Latch ch = lowest enabled index strictly greater than the last channel, wrapping to index 0. Drive it on o_ch_sel.
  - o_ch_sel is held constant from CLEAR through CAPTURE.
  - → INTEG.
- INTEG:
  - o_int_en=1 for exactly N consecutive cycles, using a down-counter.
  - After the Nth cycle: go to WAIT if o_valid=1 and i_ready=0; otherwise go to CAPTURE.
- WAIT:
  - o_int_en=0, so the integrator holds its value.
  - Leave for CAPTURE on the cycle where o_valid=1 and i_ready=1, or when o_valid is already 0.
- CAPTURE (1 cycle):
  - o_data <= i_int_y and o_ch <= ch; o_valid goes to 1 at the same edge.
  - The last-channel pointer is updated to ch.
  - Next state: CLEAR if i_run=1 and the current i_ch_mask != 0; else IDLE.
- Output register:
  - Single entry.
  - o_valid clears at the edge where o_valid and i_ready are both high, unless CAPTURE loads a new result at that same edge; the load wins and o_valid stays 1.
  - o_data and o_ch are stable while o_valid=1 and i_ready=0.
- Latency with no stall:
  - One conversion = N+2 cycles (CLEAR + N×INTEG + CAPTURE).
  - o_valid rises at the edge ending CAPTURE.
  - Back-to-back conversions give one result every N+2 cycles.
- Runtime changes:
  - i_run falling mid-conversion: the conversion completes and its result is delivered.
  - Mask or OSR changes take effect only at the next CLEAR.
  - A channel removed from the mask mid-conversion still completes.
- Arithmetic:
  - The scheduler does no arithmetic on the data.
  - The integrator width must cover N × max input; overflow wraps in the integrator and is not detected here.
- o_busy = (state != IDLE). It stays 0 after CAPTURE → IDLE, even if o_valid is still pending.

Test Plan:
- Latency: NCH=4, mask=4'b0001, i_osr=4, x=1 on ch0, i_ready=1, run pulse held high.
  - o_int_rst for 1 cycle, o_int_en for 4 cycles.
  - o_valid rises 6 cycles after CLEAR with o_data=4, o_ch=0.
  - Subsequent results every 6 cycles.
- Round robin: mask=4'b1010, i_osr=2, i_ready=1 → o_ch sequence 1,3,1,3. o_ch_sel matches each o_ch during its INTEG phase.
- Backpressure: i_ready=0 for 20 cycles.
  - The first result stays held and stable.
  - The second conversion parks in WAIT with o_int_en=0.
  - After i_ready=1, the second result appears 1 cycle after the handshake, and its value equals N×x (no extra accumulation).
- Edge configurations:
  - mask=0 with i_run=1 → remains in IDLE, o_busy=0.
  - i_osr=0 → exactly 1 enable cycle, o_data=x.
- Run stop: deassert i_run during the 3rd INTEG cycle of N=8 → that result is delivered, then IDLE, o_busy=0, no further o_int_rst.
- Reset mid-operation: assert i_rst_n=0 asynchronously during INTEG (between clock edges).
  - All outputs go to 0 immediately.
  - After release, the first conversion is on the lowest enabled channel.
